// File: rtl/axis_dvi_timing_out.sv
// axis_dvi_timing_out: AXI4-Stream video to DVI raster timing with frame lock and underflow recovery (optional AXIS_DVI_TEST_PATTERN_EN colour bars)
module axis_dvi_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        clr_status,
`ifdef AXIS_DVI_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic        s_axis_tready,
    output logic [23:0] vid_data,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic        locked,
    output logic        underflow
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOT);
    localparam int VW = $clog2(V_TOT);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {SEARCH, WAIT, LOCKED} state_t;

    state_t      st, nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic        active, hs, vs, origin, frame_end;
    logic        rdy, err;
    logic [23:0] pix;
    logic        unused_tlast;

    assign unused_tlast = s_axis_tlast;
    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs        = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign vs        = (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign origin    = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign locked    = (st == LOCKED);
    // Ready is forced low while reset is held so the stream sees no handshake during reset.
    assign s_axis_tready = resetn && rdy;

`ifdef AXIS_DVI_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    int          bar_idx;
    logic [2:0]  bar;
    logic [23:0] bar_rgb;

    // Eight equal-width bars; R/G/B bits fall out of the bar index directly.
    always_comb begin
        bar_idx = int'(h_cnt) / BAR_W;
        bar     = (bar_idx > 7) ? 3'd7 : 3'(bar_idx);
        bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
`endif

    // Free-running raster counters; they never stall regardless of lock state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) st <= SEARCH;
        else         st <= nxt;
    end

    // Next state, stream ready, error detection and pixel selection.
    always_comb begin
        nxt = st;
        rdy = 1'b0;
        err = 1'b0;
        pix = '0;
        case (st)
            SEARCH: begin
                rdy = ~s_axis_tuser;
                if (s_axis_tvalid && s_axis_tuser) nxt = WAIT;
            end
            WAIT: begin
                if (frame_end) nxt = LOCKED;
            end
            LOCKED: begin
                rdy = active && !(s_axis_tuser && !origin);
                if (active && !s_axis_tvalid) begin
                    err = 1'b1;
                    nxt = SEARCH;
                end else if (active && s_axis_tuser && !origin) begin
                    err = 1'b1;
                    nxt = WAIT;
                end else if (active) begin
                    pix = s_axis_tdata;
                    if (origin && !s_axis_tuser) begin
                        err = 1'b1;
                        nxt = SEARCH;
                    end
                end
            end
            default: nxt = SEARCH;
        endcase
`ifdef AXIS_DVI_TEST_PATTERN_EN
        if (test_pattern) begin
            nxt = SEARCH;
            rdy = 1'b1;
            err = 1'b0;
            pix = active ? bar_rgb : '0;
        end
`endif
    end

    // Registered video outputs, one clock behind the counters that produced them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vid_data  <= '0;
            vid_de    <= 1'b0;
            vid_hsync <= ~SYNC_POL;
            vid_vsync <= ~SYNC_POL;
        end else begin
            vid_data  <= pix;
            vid_de    <= active;
            vid_hsync <= hs ? SYNC_POL : ~SYNC_POL;
            vid_vsync <= vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Sticky underflow flag; a new error in the same clock beats the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         underflow <= 1'b0;
        else if (err)        underflow <= 1'b1;
        else if (clr_status) underflow <= 1'b0;
    end

endmodule

// File: doc/axis_dvi_timing_out.md
Name: axis_dvi_timing_out

Overview:
- Pixel-clock-domain stage directly downstream of the video frame-buffer reader.
- Consumes that reader's AXI4-Stream video: 24-bit RGB, tuser = start-of-frame, tlast = end-of-line.
- Regenerates raster timing and drives vid_data / vid_hsync / vid_vsync / vid_de into the DVI/TMDS encoder.
- Locks stream frames to its own timing, blanks on underflow and re-acquires automatically.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active sync level (0 = active-low, 1 = active-high)

Ports:
clk  in  1  pixel clock, the only clock
resetn  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  24  pixel {R[23:16],G[15:8],B[7:0]}
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tuser  in  1  start-of-frame marker
s_axis_tlast  in  1  end-of-line marker (ignored for timing)
vid_data  out  24  registered pixel to encoder
vid_hsync  out  1  registered horizontal sync
vid_vsync  out  1  registered vertical sync
vid_de  out  1  registered data enable
locked  out  1  high while in LOCKED
underflow  out  1  sticky error flag; cleared by clr_status
clr_status  in  1  synchronous clear of underflow

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOT-1 (H_TOT = sum of H_*), wraps to 0 and then increments v_cnt.
  - v_cnt runs 0..V_TOT-1 and wraps to 0.
  - Both free-run from reset.
- Timing decode:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Asserted level = SYNC_POL.
- Output latency: all vid_* outputs are registered, 1 clk after the counter value that produced them.
- Blanking: vid_data = 0 whenever vid_de = 0.
- Reset values:
  - counters = 0, state = SEARCH.
  - vid_data = 0, vid_de = 0, vid_hsync = vid_vsync = ~SYNC_POL.
  - locked = 0, underflow = 0, s_axis_tready = 0.
- State machine:
  - SEARCH:
    - tready = ~tuser, so non-SOF beats are consumed and dropped.
    - When tvalid && tuser: SOF beat is held (not consumed); go to WAIT.
  - WAIT:
    - tready = 0.
    - At h_cnt == H_TOT-1 && v_cnt == V_TOT-1, go to LOCKED.
  - LOCKED:
    - tready = active && !(tuser && !origin), where origin = (h_cnt == 0 && v_cnt == 0).
    - An accepted beat drives vid_data on the next clk.
- Error handling in LOCKED:
  - Underflow (active && !tvalid):
    - output black with de = 1;
    - set underflow;
    - go to SEARCH.
  - Early SOF (active && tvalid && tuser && !origin):
    - beat not consumed;
    - output black with de = 1;
    - set underflow;
    - go to WAIT.
  - Missing SOF (origin && tvalid && !tuser):
    - beat consumed and displayed;
    - set underflow;
    - go to SEARCH.
- Common rules:
  - Timing counters never stop; sync and de outputs stay correct in every state.
  - de = active in all states; video is black unless in LOCKED.
  - clr_status together with a new error in the same clk: the set wins.
  - Reset asserted mid-frame: everything returns to its reset value immediately (asynchronously).

Optional Feature:
- Macro: AXIS_DVI_TEST_PATTERN_EN.
- When defined:
  - adds input test_pattern (1 bit);
  - when high, vid_data shows 8 vertical colour bars (each H_ACTIVE/8 wide: white, yellow, cyan, green, magenta, red, blue, black);
  - s_axis_tready = 1 (stream drained);
  - state is forced to SEARCH;
  - underflow is not set.
- When not defined: port absent, no pattern logic.

Test Plan:
1. Small timing (H 8/2/2/2, V 4/1/1/1), no stream input → hsync low at h_cnt 10..11; vsync low on line 5; de high for 8 clks per active line; vid_data = 0; locked = 0.
2. Stream starts mid-frame with 3 non-SOF beats, then an SOF frame of 0x000001..0x000020 → 3 beats dropped; locked rises at the next frame origin; vid_data sequence matches 1 clk after de.
3. Locked stream, tvalid dropped at line 2 pixel 3 → that pixel is 0 with de = 1; underflow = 1; locked = 0; re-lock on the next SOF; underflow stays set until clr_status.
4. Locked stream, tuser asserted at line 1 pixel 0 → tready = 0 for that beat; state WAIT; the same beat is shown at the next origin.
5. Locked stream, origin beat with tuser = 0 → beat displayed, underflow set, state SEARCH.
6. Assert resetn = 0 mid-line during LOCKED → all outputs take reset values within the same clk; after release, timing restarts from h_cnt = 0, v_cnt = 0.
